ss_seq: RTL and testbench

SS_SEQ -- requirements
Module: ss_seq

---
 rtl/ss_seq.sv | 196 +++++++++++++++++++
 tb/tb_ss_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ss_seq.sv
// rtl/ss_seq.sv - mapper save-state sequencer (save/load stream); define SS_SEQ_IDX_EN for the map-index header byte
module ss_seq (
    input  logic       m2,
    input  logic       map_rst,
    input  logic       start,
    input  logic       dir,
    input  logic [6:0] len,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       ss_act,
    output logic       ss_we,
    output logic [7:0] ss_addr,
    output logic [7:0] ss_dout,
    input  logic [7:0] ss_rdat,
    output logic [7:0] o_dat,
    output logic       o_vld,
    input  logic       o_rdy,
    input  logic [7:0] i_dat,
    input  logic       i_vld,
    output logic       i_rdy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        IDX  = 3'd1,
        RD   = 3'd2,
        OUT  = 3'd3,
        WAIT = 3'd4,
        STB  = 3'd5,
        DONE = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] index_q, index_d;
    logic [6:0] len_q, len_d;
    logic       dir_q, dir_d;
    logic       err_q, err_d;
    logic [7:0] o_dat_q, o_dat_d;
    logic [7:0] ss_dout_q, ss_dout_d;
    logic [6:0] index_inc;
    logic       last;
`ifdef SS_SEQ_IDX_EN
    // hdr_q marks that the map-index byte is still outstanding on the stream
    logic       hdr_q, hdr_d;
    logic [7:0] idx_q, idx_d;
`endif

    assign err     = err_q;
    assign o_dat   = o_dat_q;
    assign ss_dout = ss_dout_q;

    // Next-state and per-state output decode; every output defaults to inactive
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        len_d     = len_q;
        dir_d     = dir_q;
        err_d     = err_q;
        o_dat_d   = o_dat_q;
        ss_dout_d = ss_dout_q;
`ifdef SS_SEQ_IDX_EN
        hdr_d     = hdr_q;
        idx_d     = idx_q;
`endif
        busy      = (state_q != IDLE);
        done      = 1'b0;
        ss_act    = 1'b0;
        ss_we     = 1'b0;
        ss_addr   = 8'd0;
        o_vld     = 1'b0;
        i_rdy     = 1'b0;
        // index < len <= 126, so the increment cannot wrap
        index_inc = index_q + 7'd1;
        last      = (index_inc >= len_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == 7'd0 || len == 7'd127) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        index_d = 7'd0;
                        len_d   = len;
                        dir_d   = dir;
`ifdef SS_SEQ_IDX_EN
                        hdr_d   = 1'b1;
                        state_d = IDX;
`else
                        state_d = dir ? WAIT : RD;
`endif
                    end
                end
            end
`ifdef SS_SEQ_IDX_EN
            IDX: begin
                ss_act  = 1'b1;
                ss_addr = 8'd127;
                if (dir_q) begin
                    idx_d   = ss_rdat;
                    state_d = WAIT;
                end else begin
                    o_dat_d = ss_rdat;
                    state_d = OUT;
                end
            end
`endif
            RD: begin
                ss_act  = 1'b1;
                ss_addr = {1'b0, index_q};
                o_dat_d = ss_rdat;
                state_d = OUT;
            end
            OUT: begin
                o_vld = 1'b1;
                if (o_rdy) begin
                    index_d = index_inc;
                    state_d = last ? DONE : RD;
`ifdef SS_SEQ_IDX_EN
                    // header byte does not consume a register slot
                    if (hdr_q) begin
                        hdr_d   = 1'b0;
                        index_d = index_q;
                        state_d = RD;
                    end
`endif
                end
            end
            WAIT: begin
                i_rdy = 1'b1;
                if (i_vld) begin
                    ss_dout_d = i_dat;
                    state_d   = STB;
`ifdef SS_SEQ_IDX_EN
                    // first loaded byte must match the mapper's own index
                    if (hdr_q) begin
                        ss_dout_d = ss_dout_q;
                        hdr_d     = 1'b0;
                        if (i_dat != idx_q) begin
                            err_d   = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = WAIT;
                        end
                    end
`endif
                end
            end
            STB: begin
                ss_act  = 1'b1;
                ss_we   = 1'b1;
                ss_addr = {1'b0, index_q};
                index_d = index_inc;
                state_d = last ? DONE : WAIT;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset aborts any transfer immediately
    always_ff @(negedge m2) begin
        if (map_rst) begin
            state_q   <= IDLE;
            index_q   <= 7'd0;
            len_q     <= 7'd0;
            dir_q     <= 1'b0;
            err_q     <= 1'b0;
            o_dat_q   <= 8'd0;
            ss_dout_q <= 8'd0;
`ifdef SS_SEQ_IDX_EN
            hdr_q     <= 1'b0;
            idx_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            len_q     <= len_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
            o_dat_q   <= o_dat_d;
            ss_dout_q <= ss_dout_d;
`ifdef SS_SEQ_IDX_EN
            hdr_q     <= hdr_d;
            idx_q     <= idx_d;
`endif
        end
    end

endmodule

// File: tb/tb_ss_seq.sv
// tb/tb_ss_seq.sv - scoreboard bench for ss_seq
module tb_ss_seq;
    logic       m2 = 1'b0;
    logic       map_rst = 1'b1;
    logic       start = 1'b0;
    logic       dir = 1'b0;
    logic [6:0] len = 7'd0;
    logic       busy, done, err, ss_act, ss_we;
    logic [7:0] ss_addr, ss_dout, ss_rdat, o_dat, i_dat;
    logic       o_vld, o_rdy, i_vld, i_rdy;

    logic [7:0] mem [256];
    logic [7:0] ld [8];
    logic [7:0] exp_o [$];
    logic [15:0] exp_we [$];
    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int we_cnt = 0;
    int act_cnt = 0;

    assign ss_rdat = mem[ss_addr];

    ss_seq dut (
        .m2(m2), .map_rst(map_rst), .start(start), .dir(dir), .len(len),
        .busy(busy), .done(done), .err(err), .ss_act(ss_act), .ss_we(ss_we),
        .ss_addr(ss_addr), .ss_dout(ss_dout), .ss_rdat(ss_rdat),
        .o_dat(o_dat), .o_vld(o_vld), .o_rdy(o_rdy),
        .i_dat(i_dat), .i_vld(i_vld), .i_rdy(i_rdy)
    );

    always #5 m2 = ~m2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples mid-cycle, pops expected stream bytes and register writes
    always @(posedge m2) begin
        if (!map_rst) begin
            if (done) done_cnt++;
            if (ss_act) act_cnt++;
            if (o_vld && o_rdy) begin
                if (exp_o.size() == 0) chk("o_unexpected", exp_o.size(), 1);
                else chk("o_dat", o_dat, exp_o.pop_front());
            end
            if (ss_we) begin
                we_cnt++;
                chk("we_has_act", ss_act, 1);
                if (exp_we.size() == 0) chk("we_unexpected", exp_we.size(), 1);
                else chk("we_addr_data", {ss_addr, ss_dout}, exp_we.pop_front());
            end
`ifndef SS_SEQ_IDX_EN
            if (ss_act) chk("addr7_low", ss_addr[7], 0);
`endif
        end
    end

    task automatic tick;
        @(negedge m2);
        #1;
    endtask

    task automatic go(input logic d, input logic [6:0] l);
        dir = d;
        len = l;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        i_dat = b;
        i_vld = 1'b1;
        t = 0;
        while (!i_rdy && t < 100) begin
            tick;
            t++;
        end
        if (t >= 100) chk("i_rdy_timeout", t, 0);
        tick;
        i_vld = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (!done && t < 200) begin
            tick;
            t++;
        end
        chk(name, done, 1);
    endtask

    task automatic run_save(input int n, input int stall_beat);
        int cyc, beat, stall, exp_cyc, d0;
        logic [7:0] held;
        bit stable;
`ifdef SS_SEQ_IDX_EN
        exp_o.push_back(mem[127]);
        exp_cyc = 2 * n + 2;
`else
        exp_cyc = 2 * n;
`endif
        for (int i = 0; i < n; i++) exp_o.push_back(mem[i]);
        if (stall_beat >= 0) exp_cyc += 10;
        o_rdy = 1'b1;
        beat = 0;
        stall = 0;
        stable = 1'b1;
        held = 8'd0;
        cyc = 0;
        d0 = done_cnt;
        go(1'b0, 7'(n));
        chk("save_busy", busy, 1);
        while (!done && cyc < 1000) begin
            tick;
            cyc++;
            if (stall_beat >= 0 && beat == stall_beat && stall <= 10 && (o_vld || stall > 0)) begin
                if (stall == 0) held = o_dat;
                else if (o_dat !== held || !o_vld) stable = 1'b0;
                if (ss_act) stable = 1'b0;
                o_rdy = (stall == 10);
                stall++;
            end
            if (o_vld && o_rdy) beat++;
        end
        chk("save_cycles", cyc, exp_cyc);
        if (stall_beat >= 0) begin
            chk("stall_stable", stable, 1);
            chk("stall_len", stall, 11);
        end
        tick;
        chk("save_idle", busy, 0);
        chk("save_done_cnt", done_cnt - d0, 1);
        chk("save_q_empty", exp_o.size(), 0);
        o_rdy = 1'b1;
    endtask

    task automatic run_load(input int n, input int nsend, input int gap);
        go(1'b1, 7'(n));
`ifdef SS_SEQ_IDX_EN
        send_byte(mem[127]);
`endif
        for (int k = 0; k < nsend; k++) begin
            repeat (gap) tick;
            exp_we.push_back({8'(k), ld[k]});
            send_byte(ld[k]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit, got %0d mismatched so far", n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w0, a0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
        mem[127] = 8'h12;
        o_rdy = 1'b1;
        i_vld = 1'b0;
        i_dat = 8'd0;

        repeat (3) tick;
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_act_we", {ss_act, ss_we, o_vld, i_rdy, done}, 0);
        chk("rst_addr", ss_addr, 0);
        chk("rst_data", {o_dat, ss_dout}, 0);
        map_rst = 1'b0;
        tick;

        // save 16 bytes, always ready
        run_save(16, -1);
        // save with a 10-cycle stall on byte 5
        run_save(8, 5);

        // load 3 bytes with 4-cycle gaps
        ld[0] = 8'hA5; ld[1] = 8'h5A; ld[2] = 8'h3C;
        d0 = done_cnt;
        w0 = we_cnt;
        run_load(3, 3, 4);
        wait_done("load_done_seen");
        tick;
        tick;
        chk("load_we_count", we_cnt - w0, 3);
        chk("load_done_count", done_cnt - d0, 1);
        chk("load_err", err, 0);
        chk("load_q_empty", exp_we.size(), 0);

        // illegal lengths
        a0 = act_cnt;
        go(1'b0, 7'd0);
        chk("len0_err", err, 1);
        chk("len0_busy", busy, 0);
        tick;
        chk("len0_no_act", act_cnt - a0, 0);
        go(1'b0, 7'd127);
        chk("len127_err", err, 1);
        chk("len127_busy", busy, 0);

        // len=1 clears err; start held into busy is ignored
`ifdef SS_SEQ_IDX_EN
        exp_o.push_back(mem[127]);
`endif
        exp_o.push_back(mem[0]);
        d0 = done_cnt;
        dir = 1'b0;
        len = 7'd1;
        start = 1'b1;
        tick;
        chk("len1_err_clear", err, 0);
        dir = 1'b1;
        len = 7'd5;
        tick;
        start = 1'b0;
        wait_done("len1_done_seen");
        tick;
        tick;
        chk("len1_done_count", done_cnt - d0, 1);
        chk("len1_idle", busy, 0);
        chk("len1_q_empty", exp_o.size(), 0);

        // reset mid-load after 2 of 8 bytes
        for (int k = 0; k < 8; k++) ld[k] = 8'h11 * 8'(k + 1);
        d0 = done_cnt;
        w0 = we_cnt;
        run_load(8, 2, 1);
        begin
            int t;
            t = 0;
            while (!i_rdy && t < 20) begin
                tick;
                t++;
            end
        end
        i_dat = ld[2];
        i_vld = 1'b1;
        map_rst = 1'b1;
        tick;
        chk("abort_busy", busy, 0);
        chk("abort_outs", {ss_act, ss_we, i_rdy, done, err}, 0);
        chk("abort_dout", ss_dout, 0);
        map_rst = 1'b0;
        i_vld = 1'b0;
        repeat (5) tick;
        chk("abort_we_count", we_cnt - w0, 2);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_busy_after", busy, 0);

`ifdef SS_SEQ_IDX_EN
        // wrong map index on load
        d0 = done_cnt;
        w0 = we_cnt;
        go(1'b1, 7'd2);
        send_byte(8'h13);
        wait_done("idx_done_seen");
        tick;
        chk("idx_err", err, 1);
        chk("idx_no_we", we_cnt - w0, 0);
        chk("idx_done_count", done_cnt - d0, 1);
`endif

        chk("final_o_empty", exp_o.size(), 0);
        chk("final_we_empty", exp_we.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
